// File: rtl/mem_reader_pkg.sv
// mem_reader_pkg: definitions shared by the memory-to-UART reader and the
// RX-side memory writer.
//   DEFAULT_ADDR_W : default memory address width
//   state_t        : reader FSM state encoding
package mem_reader_pkg;

    localparam int DEFAULT_ADDR_W = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH      = 3'd1,
        WAIT_RD    = 3'd2,
        SEND       = 3'd3,
        WAIT_TX    = 3'd4,
        CKSUM      = 3'd5,
        CKSUM_WAIT = 3'd6,
        DONE       = 3'd7
    } state_t;

endpackage

// File: rtl/mem_reader_tx_rd_lat_pipe.sv
// rd_lat_pipe: DEPTH-deep shift register. It delays the memory read strobe
// so that rd_valid is high in exactly the cycle in which the memory's
// read data is valid.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   rd_en    in  memory read strobe
//   rd_valid out rd_en delayed by DEPTH cycles
module rd_lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rd_en,
    output logic rd_valid
);

    logic [DEPTH-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= rd_en;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign rd_valid = pipe[DEPTH-1];

endmodule

// File: rtl/mem_reader_tx.sv
// mem_reader_tx: streams memory bytes START_ADDR..END_ADDR (inclusive) to
// the UART transmitter, one byte per frame. fin is raised once the last
// frame has completed.
// Optional build macro MEM_READER_TX_CHECKSUM_EN: an XOR checksum of all
// data bytes is appended as one extra frame.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle pulse that begins a transfer (ignored while busy)
//   rd_en     out  memory read strobe
//   rd_addr   out  memory read address
//   rd_data   in   memory read data, valid RD_LAT cycles after rd_en
//   tx_start  out  one-cycle pulse: UART loads tx_data
//   tx_data   out  byte to transmit, held from tx_start until tx_done
//   tx_done   in   one-cycle tick: UART frame complete
//   busy      out  transfer in progress
//   fin       out  transfer complete, held until the next accepted start
//
// state      | meaning
// IDLE       | waiting for start
// FETCH      | rd_en high for one cycle
// WAIT_RD    | waiting RD_LAT cycles for read data, then capture it
// SEND       | tx_start high for one cycle
// WAIT_TX    | waiting for tx_done; next address or finish
// CKSUM      | load checksum and pulse tx_start (checksum build only)
// CKSUM_WAIT | waiting for tx_done of the checksum frame
// DONE       | drop busy, raise fin
module mem_reader_tx
    import mem_reader_pkg::*;
#(
    parameter int                ADDR_W     = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = '1,
    parameter int                RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic              busy,
    output logic              fin
);

    state_t state;
    logic   rd_valid;

`ifdef MEM_READER_TX_CHECKSUM_EN
    logic [7:0] acc;
`endif

    rd_lat_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_lat_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .rd_valid (rd_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_en    <= 1'b0;
            rd_addr  <= START_ADDR;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            fin      <= 1'b0;
`ifdef MEM_READER_TX_CHECKSUM_EN
            acc      <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        fin     <= 1'b0;
                        rd_addr <= START_ADDR;
                        rd_en   <= 1'b1;
`ifdef MEM_READER_TX_CHECKSUM_EN
                        acc     <= 8'h00;
`endif
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    rd_en <= 1'b0;
                    state <= WAIT_RD;
                end
                WAIT_RD: begin
                    // rd_data is only looked at in the cycle the delayed strobe marks
                    if (rd_valid) begin
                        tx_data  <= rd_data;
`ifdef MEM_READER_TX_CHECKSUM_EN
                        acc      <= acc ^ rd_data;
`endif
                        tx_start <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    tx_start <= 1'b0;
                    state    <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        // compare before incrementing so END_ADDR = all-ones never wraps
                        if (rd_addr == END_ADDR) begin
`ifdef MEM_READER_TX_CHECKSUM_EN
                            state <= CKSUM;
`else
                            state <= DONE;
`endif
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                            rd_en   <= 1'b1;
                            state   <= FETCH;
                        end
                    end
                end
`ifdef MEM_READER_TX_CHECKSUM_EN
                CKSUM: begin
                    tx_data  <= acc;
                    tx_start <= 1'b1;
                    state    <= CKSUM_WAIT;
                end
                CKSUM_WAIT: begin
                    tx_start <= 1'b0;
                    if (tx_done) begin
                        state <= DONE;
                    end
                end
`endif
                DONE: begin
                    busy    <= 1'b0;
                    fin     <= 1'b1;
                    rd_addr <= START_ADDR;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
